// File: rtl/sram_pixel_plotter.sv
// Framebuffer write side: scales camera points to 640x480 and sets one pixel
// per plot via SRAM read-modify-write, or clears the whole 1-bpp frame.
module sram_pixel_plotter #(
  parameter int WORDS_PER_LINE = 40,
  parameter int LINES          = 480,
  parameter int CAM_INVALID    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        plot,
  input  logic        erase,
  output logic [17:0] address,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  output logic        read,
  output logic        write,
  input  logic        ready,
  output logic        busy,
  output logic        done
);

  localparam logic [17:0] LAST_ADDR =
    18'(WORDS_PER_LINE * LINES - 1);
  localparam logic [9:0] INVALID = 10'(CAM_INVALID);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    MODIFY,
    WR_WAIT,
    ERASE_WAIT,
    ERASE_GAP
  } state_t;

  state_t state, state_n;

  logic [17:0] addr_n;
  logic [15:0] wdata_n;
  logic        read_n;
  logic        write_n;
  logic        done_n;
  logic [15:0] mask_q, mask_n;
  logic [15:0] word_q, word_n;

  // x*5/8 maps 1024 -> 640 and 768 -> 480 with shifts and one add
  logic [12:0] x13;
  logic [12:0] y13;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic [17:0] sy18;
  logic [17:0] row_base;
  logic [17:0] plot_addr;
  logic [3:0]  bit_idx;
  logic [15:0] plot_mask;
  logic        point_ok;

  assign x13 = {3'b000, x} + {1'b0, x, 2'b00};
  assign y13 = {3'b000, y} + {1'b0, y, 2'b00};
  assign sx  = x13[12:3];
  assign sy  = y13[12:3];

  assign sy18      = {8'd0, sy};
  assign row_base  = (sy18 << 5) + (sy18 << 3);
  assign plot_addr = row_base + {12'd0, sx[9:4]};

  assign bit_idx   = 4'd15 - sx[3:0];
  assign plot_mask = 16'd1 << bit_idx;

  assign point_ok = (x != INVALID) &&
                    (y != INVALID) &&
                    (y < 10'd768);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      done       <= 1'b0;
      mask_q     <= '0;
      word_q     <= '0;
    end else begin
      state      <= state_n;
      address    <= addr_n;
      data_write <= wdata_n;
      read       <= read_n;
      write      <= write_n;
      done       <= done_n;
      mask_q     <= mask_n;
      word_q     <= word_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = address;
    wdata_n = data_write;
    read_n  = read;
    write_n = write;
    done_n  = 1'b0;
    mask_n  = mask_q;
    word_n  = word_q;
    unique case (state)
      IDLE: begin
        if (erase) begin
          addr_n  = '0;
          wdata_n = '0;
          write_n = 1'b1;
          state_n = ERASE_WAIT;
        end else if (plot && point_ok) begin
          addr_n  = plot_addr;
          mask_n  = plot_mask;
          read_n  = 1'b1;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ready) begin
          word_n  = data_read;
          read_n  = 1'b0;
          state_n = MODIFY;
        end
      end
      MODIFY: begin
        // pixel already lit: skip the write entirely
        if ((word_q & mask_q) != 16'd0) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          wdata_n = word_q | mask_q;
          write_n = 1'b1;
          state_n = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (ready) begin
          write_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      ERASE_WAIT: begin
        if (ready) begin
          write_n = 1'b0;
          if (address == LAST_ADDR) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ERASE_GAP;
          end
        end
      end
      ERASE_GAP: begin
        addr_n  = address + 18'd1;
        write_n = 1'b1;
        state_n = ERASE_WAIT;
      end
      default: begin
        state_n = IDLE;
        read_n  = 1'b0;
        write_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_pixel_plotter.sv
// Directed bench for sram_pixel_plotter with a small SRAM responder
// that acknowledges each request after a programmable number of cycles.
module tb_sram_pixel_plotter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        plot = 1'b0;
  logic        erase = 1'b0;
  logic [17:0] address;
  logic [15:0] data_write;
  logic [15:0] data_read = '0;
  logic        read;
  logic        write;
  logic        ready = 1'b0;
  logic        busy;
  logic        done;

  sram_pixel_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .plot       (plot),
    .erase      (erase),
    .address    (address),
    .data_write (data_write),
    .data_read  (data_read),
    .read       (read),
    .write      (write),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int          lat = 2;
  logic [15:0] rd_data = '0;
  logic        erase_mode = 1'b0;

  int          cnt = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          erase_bad = 0;
  logic [17:0] erase_next = '0;
  logic [17:0] last_raddr = '0;
  logic [17:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;
  logic        done_lat_ok = 1'b0;

  // SRAM responder and activity monitor
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_lat_ok = ready;
    end
    if (busy) busy_cnt++;
    if (ready) begin
      ready = 1'b0;
    end else if (read || write) begin
      if (cnt >= lat - 1) begin
        ready = 1'b1;
        cnt = 0;
        data_read = rd_data;
        if (read) begin
          n_reads++;
          last_raddr = address;
        end
        if (write) begin
          n_writes++;
          last_waddr = address;
          last_wdata = data_write;
          if (erase_mode) begin
            if (address != erase_next || data_write != 16'd0)
              erase_bad++;
            erase_next = address + 18'd1;
          end
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask

  task automatic wait_done(int d0, int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > d0) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rd;
    logic        acc;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wd;
  } vec_t;

  vec_t v[10];

  initial begin
    v[0] = '{10'd100,  10'd100,  16'h1000, 1'b1, 1'b1, 18'd2483,  16'h1002};
    v[1] = '{10'd0,    10'd0,    16'h0000, 1'b1, 1'b1, 18'd0,     16'h8000};
    v[2] = '{10'd1022, 10'd767,  16'h0000, 1'b1, 1'b1, 18'd19199, 16'h0002};
    v[3] = '{10'd100,  10'd100,  16'h0002, 1'b1, 1'b0, 18'd2483,  16'h0000};
    v[4] = '{10'd1023, 10'd100,  16'h0000, 1'b0, 1'b0, 18'd0,     16'h0000};
    v[5] = '{10'd100,  10'd768,  16'h0000, 1'b0, 1'b0, 18'd0,     16'h0000};
    v[6] = '{10'd100,  10'd1023, 16'h0000, 1'b0, 1'b0, 18'd0,     16'h0000};
    v[7] = '{10'd200,  10'd50,   16'hfffb, 1'b1, 1'b1, 18'd1247,  16'hffff};
    v[8] = '{10'd1022, 10'd0,    16'h8000, 1'b1, 1'b1, 18'd39,    16'h8002};
    v[9] = '{10'd0,    10'd767,  16'h0000, 1'b1, 1'b1, 18'd19160, 16'h8000};

    repeat (2) @(negedge clk);
    chk("rst_addr",  32'(address), 32'd0);
    chk("rst_wdata", 32'(data_write), 32'd0);
    chk("rst_rw",    32'({read, write}), 32'd0);
    chk("rst_busy",  32'({busy, done}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      int r0, w0, d0, b0;
      r0 = n_reads; w0 = n_writes; d0 = done_cnt; b0 = busy_cnt;
      rd_data = v[i].rd;
      x = v[i].x;
      y = v[i].y;
      plot = 1'b1;
      @(negedge clk);
      plot = 1'b0;
      chk($sformatf("v%0d_read1", i), 32'(read), 32'(v[i].acc));
      chk($sformatf("v%0d_busy1", i), 32'(busy), 32'(v[i].acc));
      if (v[i].acc) begin
        chk($sformatf("v%0d_addr1", i), 32'(address), 32'(v[i].addr));
        wait_done(d0, 40);
      end else begin
        repeat (10) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_reads", i), n_reads - r0, 32'(v[i].acc));
      chk($sformatf("v%0d_writes", i), n_writes - w0, 32'(v[i].wr));
      chk($sformatf("v%0d_dones", i), done_cnt - d0, 32'(v[i].acc));
      if (!v[i].acc)
        chk($sformatf("v%0d_nobusy", i), busy_cnt - b0, 32'd0);
      if (v[i].acc)
        chk($sformatf("v%0d_raddr", i), 32'(last_raddr), 32'(v[i].addr));
      if (v[i].wr) begin
        chk($sformatf("v%0d_waddr", i), 32'(last_waddr), 32'(v[i].addr));
        chk($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(v[i].wd));
        chk($sformatf("v%0d_donelat", i), 32'(done_lat_ok), 32'd1);
      end
    end

    begin
      int r0, w0, d0;
      r0 = n_reads; w0 = n_writes; d0 = done_cnt;
      lat = 2;
      erase_mode = 1'b1;
      erase = 1'b1;
      @(negedge clk);
      erase = 1'b0;
      chk("erase_start_wr", 32'({write, read}), 32'b10);
      chk("erase_start_addr", 32'(address), 32'd0);
      repeat (100) @(negedge clk);
      x = 10'd100;
      y = 10'd100;
      plot = 1'b1;
      @(negedge clk);
      plot = 1'b0;
      wait_done(d0, 19200 * 3 + 200);
      repeat (3) @(negedge clk);
      erase_mode = 1'b0;
      chk("erase_done", done_cnt - d0, 32'd1);
      chk("erase_writes", n_writes - w0, 32'd19200);
      chk("erase_order", erase_bad, 32'd0);
      chk("erase_last", 32'(last_waddr), 32'd19199);
      chk("erase_noread", n_reads - r0, 32'd0);
      chk("erase_idle", 32'(busy), 32'd0);
    end

    begin
      int r0;
      bit hit;
      r0 = n_reads;
      lat = 1;
      x = 10'd100;
      y = 10'd100;
      plot = 1'b1;
      erase = 1'b1;
      @(negedge clk);
      plot = 1'b0;
      erase = 1'b0;
      chk("both_rw", 32'({write, read}), 32'b10);
      chk("both_addr", 32'(address), 32'd0);
      hit = 1'b0;
      for (int i = 0; i < 12000; i++) begin
        if (write && address == 18'd5000) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("reach_5000", 32'(hit), 32'd1);
      chk("both_noread", n_reads - r0, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst_rw", 32'({write, read}), 32'd0);
      chk("arst_busy", 32'({busy, done}), 32'd0);
      chk("arst_addr", 32'(address), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      erase = 1'b1;
      @(negedge clk);
      erase = 1'b0;
      chk("restart_wr", 32'(write), 32'd1);
      chk("restart_addr", 32'(address), 32'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
